// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential 3x3 (NxN) matrix multiplier.
package matmul_pkg;

    // Controller states: operand inner product, result write-back, completion pulse.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N     = 3;

    // Row-major element index of [r][c] in an n x n matrix.
    function automatic int idx(input int r, input int c, input int n = DEFAULT_N);
        return r * n + c;
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Start/Busy/Done handshake plus flattened operand and result buses.
interface matmul_seq_ctrl_if
    import matmul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N
);
    logic                   Start;
    logic [N*N*WIDTH-1:0]   A_flat;
    logic [N*N*WIDTH-1:0]   B_flat;
    logic [N*N*WIDTH-1:0]   Out_flat;
    logic                   Busy;
    logic                   Done;

    // Requester side: issues jobs and reads results.
    modport master (
        output Start, A_flat, B_flat,
        input  Out_flat, Busy, Done
    );

    // Multiplier side.
    modport slave (
        input  Start, A_flat, B_flat,
        output Out_flat, Busy, Done
    );
endinterface

// File: rtl/matmul_seq_ctrl_mac_unit.sv
// Single shared multiply-accumulate stage; product and sum wrap at WIDTH bits.
module mac_unit
    import matmul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc
);
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] prod;

    // Truncated product, then clear has priority over accumulate.
    always_comb begin
        prod  = WIDTH'(a * b);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/matmul_seq_ctrl.sv
// Time-multiplexed NxN matrix multiplier: one MAC walks i/j/k indices,
// each result element takes N accumulate cycles plus one write-back cycle.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N
) (
    input  logic                clk,
    input  logic                Reset,
    matmul_seq_ctrl_if.slave    bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int EW = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int FW = N * N * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IW-1:0]      i_q, i_d;
    logic [IW-1:0]      j_q, j_d;
    logic [IW-1:0]      k_q, k_d;
    logic [FW-1:0]      a_q, a_d;
    logic [FW-1:0]      b_q, b_d;
    logic [WIDTH-1:0]   out_q [N*N];
    logic [WIDTH-1:0]   out_d [N*N];

    logic [WIDTH-1:0]   a_arr [N*N];
    logic [WIDTH-1:0]   b_arr [N*N];
    logic [EW-1:0]      a_idx, b_idx, wr_idx;
    logic [WIDTH-1:0]   mac_acc;
    logic               mac_clr, mac_en;
    logic               start_ok;

    // Unpack captured operands and repack the result bank.
    for (genvar gi = 0; gi < N * N; gi++) begin : g_elem
        assign a_arr[gi] = a_q[gi*WIDTH +: WIDTH];
        assign b_arr[gi] = b_q[gi*WIDTH +: WIDTH];
        assign bus.Out_flat[gi*WIDTH +: WIDTH] = out_q[gi];
    end

    assign a_idx  = EW'(idx(int'(i_q), int'(k_q), N));
    assign b_idx  = EW'(idx(int'(k_q), int'(j_q), N));
    assign wr_idx = EW'(idx(int'(i_q), int'(j_q), N));

    mac_unit #(.WIDTH(WIDTH)) u_mac (
        .clk   (clk),
        .Reset (Reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (a_arr[a_idx]),
        .b     (b_arr[b_idx]),
        .acc   (mac_acc)
    );

    // Next-state, index sequencing and write-back selection.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        start_ok = bus.Start && ((state_q == IDLE) || (state_q == DONE));

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            MAC: begin
                mac_en = 1'b1;
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = WRITE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            WRITE: begin
                out_d[wr_idx] = mac_acc;
                mac_clr       = 1'b1;
                state_d       = MAC;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d     = '0;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new job may start from IDLE or straight out of DONE.
        if (start_ok) begin
            a_d     = bus.A_flat;
            b_d     = bus.B_flat;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            mac_clr = 1'b1;
            state_d = MAC;
        end

        busy_d = (state_d == MAC) || (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    // State, registered Busy/Done, indices, operand copies and result bank.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl (3x3, 8-bit): latency, results,
// wrap-around arithmetic, back-to-back jobs, mid-job reset, ignored starts.
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int FW = N * N * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_seq_ctrl_if #(.WIDTH(W), .N(N)) bus ();

    matmul_seq_ctrl #(.WIDTH(W), .N(N)) dut (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [FW-1:0] m_ident, m_seq, m_sq, m_15, m_16, m_163, m_zero;

    function automatic logic [FW-1:0] pack9(input int v [9]);
        logic [FW-1:0] p;
        p = '0;
        for (int e = 0; e < 9; e++) p[e*W +: W] = W'(v[e]);
        return p;
    endfunction

    function automatic logic [FW-1:0] splat(input int v);
        logic [FW-1:0] p;
        for (int e = 0; e < 9; e++) p[e*W +: W] = W'(v);
        return p;
    endfunction

    // Present operands with Start high for one edge; returns just after the accepting edge.
    task automatic start_job(input logic [FW-1:0] a, input logic [FW-1:0] b);
        @(negedge clk);
        bus.A_flat = a;
        bus.B_flat = b;
        bus.Start  = 1'b1;
        @(negedge clk);
        bus.Start  = 1'b0;
    endtask

    // Count edges after acceptance until Done, and Busy samples on the way.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        while (!bus.Done && cyc < 200) begin
            if (bus.Busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
        n_cmp++; if (bus.Done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
        n_cmp++; if (bus.Out_flat !== m_zero) begin n_bad++; $display("FAIL reset_out got=%h exp=%h", bus.Out_flat, m_zero); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got=%b exp=0", bus.Busy); end
        $display("test_reset done");
    endtask

    task automatic test_identity();
        int cyc, bc;
        start_job(m_ident, m_seq);
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 36) begin n_bad++; $display("FAIL ident_latency got=%0d exp=36", cyc); end
        n_cmp++; if (bc !== 36) begin n_bad++; $display("FAIL ident_busy_cycles got=%0d exp=36", bc); end
        n_cmp++; if (bus.Out_flat !== m_seq) begin n_bad++; $display("FAIL ident_out got=%h exp=%h", bus.Out_flat, m_seq); end
        @(negedge clk);
        n_cmp++; if (bus.Done !== 1'b0) begin n_bad++; $display("FAIL ident_done_pulse got=%b exp=0", bus.Done); end
        n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL ident_busy_after got=%b exp=0", bus.Busy); end
        $display("test_identity latency=%0d busy=%0d out=%h", cyc, bc, bus.Out_flat);
    endtask

    task automatic test_square();
        int cyc, bc;
        start_job(m_seq, m_seq);
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 36) begin n_bad++; $display("FAIL square_latency got=%0d exp=36", cyc); end
        n_cmp++; if (bus.Out_flat !== m_sq) begin n_bad++; $display("FAIL square_out got=%h exp=%h", bus.Out_flat, m_sq); end
        $display("test_square out=%h", bus.Out_flat);
    endtask

    task automatic test_overflow();
        int cyc, bc;
        start_job(m_15, m_15);
        wait_done(cyc, bc);
        n_cmp++; if (bus.Out_flat !== m_163) begin n_bad++; $display("FAIL ovf15_out got=%h exp=%h", bus.Out_flat, m_163); end
        $display("test_overflow 15s out=%h", bus.Out_flat);
        start_job(m_16, m_16);
        wait_done(cyc, bc);
        n_cmp++; if (bus.Out_flat !== m_zero) begin n_bad++; $display("FAIL ovf16_out got=%h exp=%h", bus.Out_flat, m_zero); end
        $display("test_overflow 16s out=%h", bus.Out_flat);
    endtask

    task automatic test_back_to_back();
        int first, second;
        first  = -1;
        second = -1;
        @(negedge clk);
        bus.A_flat = m_seq;
        bus.B_flat = m_seq;
        bus.Start  = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc == 10) bus.A_flat = m_zero;
            if (bus.Done) begin
                if (first < 0) begin
                    first = cyc;
                    n_cmp++; if (bus.Out_flat !== m_sq) begin n_bad++; $display("FAIL b2b_first_out got=%h exp=%h", bus.Out_flat, m_sq); end
                end else begin
                    second = cyc;
                    break;
                end
            end
            if (first >= 0 && cyc == first + 1) begin
                n_cmp++; if (bus.Busy !== 1'b1) begin n_bad++; $display("FAIL b2b_no_gap busy=%b exp=1", bus.Busy); end
                n_cmp++; if (bus.Out_flat !== m_sq) begin n_bad++; $display("FAIL b2b_hold_out got=%h exp=%h", bus.Out_flat, m_sq); end
                bus.Start = 1'b0;
            end
            @(negedge clk);
        end
        bus.Start = 1'b0;
        n_cmp++; if (first !== 36) begin n_bad++; $display("FAIL b2b_first_latency got=%0d exp=36", first); end
        n_cmp++; if (second - first !== 37) begin n_bad++; $display("FAIL b2b_gap got=%0d exp=37", second - first); end
        n_cmp++; if (bus.Out_flat !== m_zero) begin n_bad++; $display("FAIL b2b_second_out got=%h exp=%h", bus.Out_flat, m_zero); end
        $display("test_back_to_back first=%0d second=%0d", first, second);
    endtask

    task automatic test_ignore_start();
        int dones, first;
        dones = 0;
        first = -1;
        start_job(m_seq, m_seq);
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (bus.Done) begin
                dones++;
                if (first < 0) first = cyc;
            end
            if (cyc == 5 || cyc == 30) begin
                bus.A_flat = m_15;
                bus.B_flat = m_15;
                bus.Start  = 1'b1;
            end
            if (cyc == 6 || cyc == 31) bus.Start = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
        n_cmp++; if (first !== 36) begin n_bad++; $display("FAIL ignore_latency got=%0d exp=36", first); end
        n_cmp++; if (bus.Out_flat !== m_sq) begin n_bad++; $display("FAIL ignore_out got=%h exp=%h", bus.Out_flat, m_sq); end
        $display("test_ignore_start dones=%0d first=%0d", dones, first);
    endtask

    task automatic test_reset_mid();
        int dones, cyc, bc;
        dones = 0;
        start_job(m_seq, m_seq);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", bus.Busy); end
        n_cmp++; if (bus.Done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b exp=0", bus.Done); end
        n_cmp++; if (bus.Out_flat !== m_zero) begin n_bad++; $display("FAIL midrst_out got=%h exp=%h", bus.Out_flat, m_zero); end
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (bus.Done) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midrst_stray_done got=%0d exp=0", dones); end
        start_job(m_ident, m_seq);
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 36) begin n_bad++; $display("FAIL midrst_restart_latency got=%0d exp=36", cyc); end
        n_cmp++; if (bus.Out_flat !== m_seq) begin n_bad++; $display("FAIL midrst_restart_out got=%h exp=%h", bus.Out_flat, m_seq); end
        $display("test_reset_mid restart latency=%0d out=%h", cyc, bus.Out_flat);
    endtask

    initial begin
        int t [9];
        bus.Start  = 1'b0;
        bus.A_flat = '0;
        bus.B_flat = '0;
        t = '{1, 0, 0, 0, 1, 0, 0, 0, 1};            m_ident = pack9(t);
        t = '{1, 2, 3, 4, 5, 6, 7, 8, 9};            m_seq   = pack9(t);
        t = '{30, 36, 42, 66, 81, 96, 102, 126, 150}; m_sq   = pack9(t);
        m_15   = splat(15);
        m_16   = splat(16);
        m_163  = splat(163);
        m_zero = splat(0);

        test_reset();
        test_identity();
        test_square();
        test_overflow();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Time-multiplexed 3x3 matrix multiplier: computes Out = A x B using one shared multiply-accumulate datapath, not one per element.
- Sequences row/column/inner-product indices and accumulates each element over N cycles, then writes it to an output register bank.
- Area-reduced alternative to the fully parallel MAC array, with the same Start/Busy/Done controller handshake.

Parameters:
- WIDTH, 8, operand, accumulator and result width in bits.
- N, 3, matrix dimension; supported range is 2..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request a multiply; accepted only when Busy=0.
- A_flat  in  N*N*WIDTH  matrix A, row-major; element [r][c] at bits (r*N+c)*WIDTH +: WIDTH.
- B_flat  in  N*N*WIDTH  matrix B, same packing as A_flat.
- Out_flat  out  N*N*WIDTH  result matrix, same packing, registered.
- Busy  out  1  high while a multiply is in progress.
- Done  out  1  one-cycle pulse when the whole result is valid.

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - State goes to IDLE; Busy=0, Done=0, Out_flat all 0.
  - Accumulator, index counters and operand copies cleared.
  - Reset takes priority over every other event, including mid-operation; the in-flight job is abandoned and no Done is issued.
- States: IDLE, MAC, WRITE, DONE.
  - Busy=1 exactly in MAC and WRITE.
  - Done=1 exactly in DONE.
  - Both outputs decode from the state register (Moore, glitch-free).
- Start acceptance:
  - Accepted at an edge where Start=1 and the state is IDLE or DONE.
  - On acceptance: capture A_flat/B_flat into internal copies; set i=j=k=0 and acc=0; go to MAC.
  - Input changes after that edge do not affect the running job.
  - Start while Busy=1 is ignored; it is neither queued nor an error.
- MAC:
  - Each cycle: acc <= acc + A[i][k]*B[k][j]; k <= k+1.
  - When k==N-1, go to WRITE and reset k to 0.
- WRITE:
  - Out[i][j] <= acc; acc <= 0.
  - Advance j; on wrap j=N-1 to 0, advance i.
  - If (i,j)==(N-1,N-1), go to DONE; else go to MAC.
- DONE:
  - Lasts one cycle, then goes to IDLE.
  - A Start seen in DONE is accepted directly, giving back-to-back jobs with no IDLE cycle.
- Latency:
  - Start accepted at edge E0; MAC/WRITE occupy N*N*(N+1) cycles (36 for N=3).
  - DONE is entered at edge E36; Done is high for the cycle between E36 and E37.
- Arithmetic:
  - Product is truncated to WIDTH bits; sum wraps modulo 2^WIDTH.
  - Unsigned; no saturation, no overflow flag.
- Output stability:
  - Out elements update one at a time as each WRITE occurs.
  - The full matrix is stable from the Done cycle until the first WRITE of the next job (N cycles after that job's accepting edge).
  - Elements not yet rewritten by the current job hold their previous values.
- Counters are $clog2(N) bits wide. With N a non-power-of-2, index values >= N never occur.

Decomposition:
- Package matmul_pkg holds:
  - State enum {IDLE, MAC, WRITE, DONE}.
  - Default WIDTH/N constants.
  - Element index function idx(r,c)=r*N+c.
- Sub-module mac_unit (WIDTH):
  - Inputs clk, Reset, clr, en, a, b; output acc.
  - Behaviour: acc <= clr ? 0 : en ? acc+a*b : acc.
- Controller and output bank stay in matmul_seq_ctrl.

Test Plan:
- A=identity, B=[[1,2,3],[4,5,6],[7,8,9]], Start one cycle → Done pulse 36 edges after acceptance; Out=B; Busy high for exactly 36 cycles.
- A=B=[[1,2,3],[4,5,6],[7,8,9]] → Out=[[30,36,42],[66,81,96],[102,126,150]].
- Overflow: A,B all 15 → every element 675 mod 256 = 163. A,B all 16 → every element 0.
- Start held high continuously with A changed to zeros mid-job → first result is unaffected. Second job starts from the DONE state with no IDLE gap; second Done comes 37 edges after the first.
- Reset asserted at cycle 20 of a job → next edge Busy=0, Done=0, Out all 0; no Done pulse follows. A new Start then completes normally.
- Start pulses during Busy (cycles 5 and 30) → ignored; exactly one Done is issued, and the results match the first operands.
